// File: rtl/instruction_cache.sv
// Direct-mapped, read-only L1 instruction cache. A hit returns the line in the same cycle.
// A miss issues one line fill, installs the returned line, and then replays it for one cycle.
module instruction_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           icache_ready,
  input  logic                           req_valid,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           rsp_valid,
  output logic [LINE_WIDTH-1:0]          rsp_data,
  output logic                           req_valid_miss,
  // Packed memory request: {addr[ADDR_WIDTH-1:0], is_store, data[LINE_WIDTH-1:0]}
  output logic [ADDR_WIDTH+LINE_WIDTH:0] req_info_miss,
  input  logic [LINE_WIDTH-1:0]          rsp_data_miss,
  input  logic                           rsp_valid_miss,
  output logic [1:0]                     debug_state
);

  // Handshake: a request is served when req_valid is high and rsp_valid answers it.
  // Fetch holds req_addr stable until rsp_valid. The memory side sees req_valid_miss
  // as a level request, and rsp_valid_miss is a one-cycle completion pulse.

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    REPLAY    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0]   data_q [NUM_LINES];
  logic [ADDR_WIDTH-1:0]   miss_addr_q;

  logic [INDEX_BITS-1:0]   req_index, miss_index;
  logic [TAG_BITS-1:0]     req_tag, miss_tag;
  logic                    hit, fill_en, miss_start;
  logic                    unused_offset;

  assign req_index     = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag       = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign miss_index    = miss_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign miss_tag      = miss_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

  assign hit        = req_valid && valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign miss_start = (state_q == IDLE) && req_valid && !hit;
  // Fills are only accepted while a miss is outstanding; stray pulses are dropped.
  assign fill_en    = (state_q == WAIT_FILL) && rsp_valid_miss;
  assign debug_state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start)
        miss_addr_q <= {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      if (fill_en)
        valid_q[miss_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[miss_index]  <= miss_tag;
      data_q[miss_index] <= rsp_data_miss;
    end
  end

  always_comb begin
    state_d        = state_q;
    icache_ready   = 1'b1;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          rsp_valid = 1'b1;
          rsp_data  = data_q[req_index];
        end else if (req_valid) begin
          state_d = WAIT_FILL;
        end
      end
      WAIT_FILL: begin
        icache_ready   = 1'b0;
        req_valid_miss = 1'b1;
        req_info_miss  = {miss_addr_q, 1'b0, {LINE_WIDTH{1'b0}}};
        if (rsp_valid_miss)
          state_d = REPLAY;
      end
      REPLAY: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q[miss_index];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios followed by randomized fetch and memory
// traffic. Both are checked every cycle against a line-level model of the cache.
module tb_instruction_cache;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int NL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          icache_ready;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic [LW-1:0] rsp_data;
  logic          req_valid_miss;
  logic [AW+LW:0] req_info_miss;
  logic [LW-1:0] rsp_data_miss = '0;
  logic          rsp_valid_miss = 1'b0;
  logic [1:0]    debug_state;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_cache #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
    .clock(clock), .reset(reset), .icache_ready(icache_ready),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss),
    .rsp_data_miss(rsp_data_miss), .rsp_valid_miss(rsp_valid_miss),
    .debug_state(debug_state)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  // Reference model: which line address sits at each index, plus the pending miss.
  typedef enum {M_IDLE, M_WAIT, M_REPLAY} mode_t;
  mode_t         m_mode = M_IDLE;
  bit            m_valid [NL];
  logic [27:0]   m_line_addr [NL];
  logic [LW-1:0] m_data [NL];
  logic [31:0]   m_miss_addr = '0;
  logic [LW-1:0] exp_q[$];
  bit            seen_req = 1'b0;

  function automatic int idx_of(logic [31:0] a);
    return int'(a[31:4]) % NL;
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line_addr[idx_of(a)] == a[31:4]);
  endfunction

  task automatic check(string name, logic [160:0] got, logic [160:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (req_valid && !m_hit(req_addr)) begin
          m_miss_addr = {req_addr[31:4], 4'h0};
          m_mode = M_WAIT;
        end
        M_WAIT: if (rsp_valid_miss) begin
          m_valid[idx_of(m_miss_addr)]     = 1'b1;
          m_line_addr[idx_of(m_miss_addr)] = m_miss_addr[31:4];
          m_data[idx_of(m_miss_addr)]      = rsp_data_miss;
          exp_q.push_back(rsp_data_miss);
          m_mode = M_REPLAY;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Scoreboard: compare every output on every falling edge.
  always @(negedge clock) begin
    logic          e_ready, e_rv, e_mv;
    logic [LW-1:0] e_data;
    logic [AW+LW:0] e_info;
    e_ready = 1'b1; e_rv = 1'b0; e_mv = 1'b0; e_data = '0; e_info = '0;
    case (m_mode)
      M_IDLE: if (req_valid && m_hit(req_addr)) begin
        e_rv = 1'b1;
        e_data = m_data[idx_of(req_addr)];
      end
      M_WAIT: begin
        e_ready = 1'b0;
        e_mv = 1'b1;
        e_info = {m_miss_addr, 1'b0, {LW{1'b0}}};
      end
      default: begin
        e_rv = 1'b1;
        e_data = m_data[idx_of(m_miss_addr)];
        if (exp_q.size() > 0) check("replay_line", rsp_data, exp_q.pop_front());
      end
    endcase
    check("icache_ready", icache_ready, e_ready);
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_data", rsp_data, e_data);
    check("req_valid_miss", req_valid_miss, e_mv);
    check("req_info_miss", req_info_miss, e_info);
    seen_req = req_valid_miss;
  end

  // Driver task: apply one cycle of inputs just after the rising edge.
  task automatic step(bit rst, bit v, logic [31:0] a, bit mv, logic [LW-1:0] md);
    @(posedge clock);
    #1;
    reset = rst; req_valid = v; req_addr = a; rsp_valid_miss = mv; rsp_data_miss = md;
  endtask

  localparam logic [LW-1:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] LINE_B = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;

  initial begin
    logic [31:0]   cur_addr;
    logic [31:0]   word;
    logic [LW-1:0] line;
    int            cd;
    bit            r, v, mv;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    check("reset_ready", icache_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_miss", req_valid_miss, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_info", req_info_miss, 0);

    // Cold miss at 0x1000 with a three-cycle memory latency.
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("cold_rsp_valid", rsp_valid, 0);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("cold_miss", req_valid_miss, 1);
    check("cold_ready", icache_ready, 0);
    check("cold_info_addr", req_info_miss[160:129], 32'h1000);
    check("cold_is_store", req_info_miss[128], 0);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("wait_miss_2", req_valid_miss, 1);
    step(0, 1, 32'h1000, 1, LINE_A);
    @(negedge clock);
    check("fill_cycle_miss", req_valid_miss, 1);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("replay_valid", rsp_valid, 1);
    check("replay_ready", icache_ready, 1);
    check("replay_data", rsp_data, LINE_A);
    step(0, 0, 32'h1000, 0, 0);
    @(negedge clock);
    check("idle_after_replay", icache_ready && !rsp_valid && !req_valid_miss, 1);

    // Same-line hits select words 1..3.
    for (int w = 1; w < 4; w++) begin
      step(0, 1, 32'h1000 + 32'(w * 4), 0, 0);
      @(negedge clock);
      line = rsp_data;
      word = line[w*32 +: 32];
      check("hit_valid", rsp_valid, 1);
      check("hit_no_miss", req_valid_miss, 0);
      check("hit_word", word, 32'h11111111 * 32'(w + 1));
    end

    // Conflict on index 0: 0x1040 evicts 0x1000, then 0x1000 misses again.
    step(0, 1, 32'h1040, 0, 0);
    @(negedge clock);
    check("conflict_miss", rsp_valid, 0);
    step(0, 1, 32'h1040, 0, 0);
    @(negedge clock);
    check("conflict_info", req_info_miss[160:129], 32'h1040);
    step(0, 1, 32'h1040, 1, LINE_B);
    step(0, 1, 32'h1040, 0, 0);
    @(negedge clock);
    check("conflict_replay", rsp_data, LINE_B);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("evicted_miss", rsp_valid, 0);
    step(0, 1, 32'h1000, 1, LINE_A);
    step(0, 1, 32'h1000, 0, 0);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("refill_hit", rsp_data, LINE_A);

    // Reset during WAIT_FILL, then a late fill pulse that must be ignored.
    step(0, 1, 32'h1040, 0, 0);
    step(0, 1, 32'h1040, 0, 0);
    @(negedge clock);
    check("pre_reset_wait", req_valid_miss, 1);
    step(1, 1, 32'h1040, 0, 0);
    step(0, 0, 32'h1040, 1, LINE_B);
    @(negedge clock);
    check("late_fill_ready", icache_ready, 1);
    check("late_fill_no_miss", req_valid_miss, 0);
    step(0, 1, 32'h1000, 0, 0);
    @(negedge clock);
    check("post_reset_miss", rsp_valid, 0);
    step(0, 1, 32'h1000, 1, LINE_A);
    step(0, 1, 32'h1000, 0, 0);
    step(0, 0, 32'h1000, 0, 0);
    @(negedge clock);
    check("idle_no_rsp", rsp_valid, 0);
    check("idle_no_miss", req_valid_miss, 0);

    // Randomized traffic: 16 lines over 4 indices, random latency, stray pulses, resets.
    cd = -1;
    cur_addr = 32'h1000;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      mv = 1'b0;
      if (m_mode == M_IDLE) begin
        cur_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 16 + 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) cur_addr = cur_addr | 32'h8000_0000;
        if ($urandom_range(0, 15) == 0) mv = 1'b1;
      end else if (m_mode == M_WAIT && $urandom_range(0, 3) == 0) begin
        req_addr = $urandom;
      end
      if (cd < 0 && seen_req) cd = int'($urandom_range(0, 4));
      if (cd == 0) begin
        mv = 1'b1;
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      reset = r;
      req_valid = v;
      if (!(m_mode == M_WAIT && req_addr != cur_addr && $urandom_range(0, 1) == 0))
        req_addr = cur_addr;
      rsp_valid_miss = mv;
      rsp_data_miss = {$urandom, $urandom, $urandom, $urandom};
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
Direct-mapped, read-only L1 instruction cache sitting between the fetch-stage program counter and the memory hierarchy. A hit returns the whole cache line combinationally in the same cycle as the request. A miss issues a line-fill request to memory, stalls via icache_ready, installs the returned line, then replays the response for the still-held address. Fetch selects the 32-bit instruction from the line using req_addr[3:2].

Parameters:
ADDR_WIDTH, 32, width of req_addr (PC_WIDTH).
LINE_WIDTH, 128, cache line width in bits (ICACHE_LINE_WIDTH; four 32-bit instructions).
NUM_LINES, 4, number of direct-mapped lines; power of two, at least 2.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
icache_ready  output  1  cache can accept or complete a request; low while a fill is outstanding.
req_valid  input  1  fetch request valid (already gated by stall in fetch).
req_addr  input  ADDR_WIDTH  byte address of the request; held stable by fetch until rsp_valid.
rsp_valid  output  1  rsp_data is valid for req_addr.
rsp_data  output  LINE_WIDTH  full cache line containing req_addr.
req_valid_miss  output  1  line-fill request to memory.
req_info_miss  output  memory_request_t  packed {addr[ADDR_WIDTH-1:0], is_store, data[LINE_WIDTH-1:0]} = 161 bits; addr = {req_addr[31:4],4'b0}, is_store=0, data=0.
rsp_data_miss  input  LINE_WIDTH  fill data from memory.
rsp_valid_miss  input  1  fill data valid; one-cycle pulse.

Behaviour:
- Address split: offset = addr[3:0]; index = addr[4+log2(NUM_LINES)-1:4]; tag = remaining upper bits.
- Storage per line: valid bit, tag, and LINE_WIDTH data bits.
- Reset: all valid bits cleared; state=IDLE. Outputs after reset: icache_ready=1, rsp_valid=0, req_valid_miss=0, rsp_data=0, req_info_miss=0. Tag and data arrays need no reset.
- hit = req_valid & valid[index] & (tag match).
- IDLE:
  - icache_ready=1.
  - On hit: rsp_valid=1 and rsp_data=line, both combinational in the same cycle (zero latency). No state change.
  - On req_valid & !hit: rsp_valid=0; latch the line-aligned address into the miss register; next state WAIT_FILL.
- WAIT_FILL:
  - icache_ready=0, rsp_valid=0.
  - req_valid_miss=1 (level), held every cycle until rsp_valid_miss; req_info_miss driven from the miss register.
  - req_valid is ignored in this state.
  - On rsp_valid_miss: write rsp_data_miss into data[index], write tag, set valid; req_valid_miss still 1 that cycle. Next state REPLAY.
- REPLAY (exactly one cycle):
  - icache_ready=1, rsp_valid=1 regardless of req_valid; rsp_data = newly filled line.
  - Next state IDLE.
- Miss-to-response latency is 1 cycle to the request plus the memory latency plus 1 replay cycle.
- Only one miss is outstanding at a time. A fill overwrites the previous line at that index (no LRU, no write path, no invalidation other than reset).
- When not in WAIT_FILL, req_info_miss is 0 and req_valid_miss is 0.
- rsp_valid_miss arriving in IDLE or REPLAY is ignored and the arrays are not written.
- Reset asserted mid-miss: return to IDLE, clear all valid bits, drop the pending request. A later rsp_valid_miss is ignored.
- A req_addr change during WAIT_FILL has no effect on the fill; the miss register controls the fill.

Test Plan:
1. Reset, then req_valid=1, req_addr=0x1000 (cold) -> rsp_valid=0 that cycle; next cycle req_valid_miss=1, icache_ready=0, req_info_miss.addr=0x1000, is_store=0.
2. Memory returns rsp_valid_miss with 0x44444444_33333333_22222222_11111111 after 3 cycles -> req_valid_miss stays 1 until then; next cycle rsp_valid=1, icache_ready=1, rsp_data equals that line; following cycle state IDLE.
3. After the fill, req_valid=1 at addr 0x1004, then 0x1008, then 0x100C -> rsp_valid=1 same cycle each time, req_valid_miss never asserted, data word [3:2] selects 0x22222222, 0x33333333, 0x44444444.
4. Conflict: fill 0x1000, then request 0x1040 (same index, NUM_LINES=4) -> miss, fill; re-request 0x1000 -> miss again.
5. Reset asserted during WAIT_FILL, then a late rsp_valid_miss -> ignored; request to 0x1000 misses again with icache_ready=1 beforehand.
6. req_valid=0 with valid lines present -> rsp_valid=0 and req_valid_miss=0.
